// File: rtl/output_accum_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the output accumulation sequencer.
package output_accum_ctrl_pkg;

    localparam int unsigned LANES                = 8;
    localparam int unsigned MAC_OUTPUT_WIDTH_DEF = 8;
    localparam int unsigned READ_LATENCY_DEF     = 3;
    localparam int unsigned PASS_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // True when idx is the final pass of a job with cnt passes.
    function automatic logic is_last_pass(logic [PASS_W-1:0] idx, logic [PASS_W-1:0] cnt);
        return idx == (cnt - PASS_W'(1));
    endfunction

endpackage

// File: rtl/output_accum_ctrl_adder.sv
// 8-lane wrap-around adder with pass-0 bypass; routes the registered sum to
// either the buffer write port or the downstream output port.
module accum_lane_adder
    import output_accum_ctrl_pkg::*;
#(
    parameter int unsigned W = MAC_OUTPUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 first_i,
    input  logic                 last_i,
    input  logic [LANES*W-1:0]   mac_i,
    input  logic [LANES*W-1:0]   feat_i,
    output logic [LANES*W-1:0]   wr_data_o,
    output logic                 wr_valid_o,
    output logic [LANES*W-1:0]   out_data_o,
    output logic                 out_valid_o
);

    localparam int unsigned DW = LANES * W;

    logic [DW-1:0] sum_c;
    logic [DW-1:0] wr_data_q;
    logic [DW-1:0] out_data_q;
    logic          wr_valid_q;
    logic          out_valid_q;

    // Per-lane sum; first pass has no prior partial sum to add.
    always_comb begin
        sum_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sum_c[l*W +: W] = first_i ? mac_i[l*W +: W]
                                      : W'(mac_i[l*W +: W] + feat_i[l*W +: W]);
        end
    end

    // Register the sum onto the write port or the final-output port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_data_q   <= '0;
            out_data_q  <= '0;
            wr_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_valid_q  <= valid_i & ~last_i;
            out_valid_q <= valid_i & last_i;
            if (valid_i && !last_i) wr_data_q  <= sum_c;
            if (valid_i && last_i)  out_data_q <= sum_c;
        end
    end

    assign wr_data_o   = wr_data_q;
    assign wr_valid_o  = wr_valid_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/output_accum_ctrl.sv
// Pass sequencer for the convolution output buffer: accumulates MAC beats onto
// buffered partial sums and streams final sums on the last pass.
module output_accum_ctrl
    import output_accum_ctrl_pkg::*;
#(
    parameter int unsigned MAC_OUTPUT_WIDTH = MAC_OUTPUT_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH       = 15,
    parameter int unsigned READ_LATENCY     = READ_LATENCY_DEF
) (
    input  logic                              system_clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_WIDTH:0]               pixel_count,
    input  logic [7:0]                        pass_count,
    input  logic                              mac_valid,
    output logic                              mac_ready,
    input  logic [8*MAC_OUTPUT_WIDTH-1:0]     mac_data,
    output logic                              refresh_req,
    output logic                              adder_pulse,
    input  logic [8*MAC_OUTPUT_WIDTH-1:0]     adder_feature,
    output logic [8*MAC_OUTPUT_WIDTH-1:0]     feature_in,
    output logic                              feature_valid,
    output logic                              out_valid,
    output logic [8*MAC_OUTPUT_WIDTH-1:0]     out_data,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned DW = LANES * MAC_OUTPUT_WIDTH;
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned RL = READ_LATENCY;

    state_e              state_q, state_d;
    logic [CW-1:0]       pix_q, pix_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;

    logic                mac_ready_q, mac_ready_d;
    logic                refresh_q, refresh_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DW-1:0]       pipe_data_q [RL];
    logic [RL-1:0]       pipe_vld_q;
    logic [RL-1:0]       pipe_first_q;
    logic [RL-1:0]       pipe_last_q;

    logic                accept_c;
    logic                last_pass_c;
    logic                drain_empty_c;
    logic                wr_valid;
    logic                fin_valid;

    assign accept_c      = mac_valid & mac_ready_q;
    assign last_pass_c   = is_last_pass(pass_idx_q, passes_q);
    assign drain_empty_c = ~(|pipe_vld_q) & ~wr_valid & ~fin_valid;

    // State, counters and registered control outputs.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pix_q       <= '0;
            beat_cnt_q  <= '0;
            passes_q    <= '0;
            pass_idx_q  <= '0;
            mac_ready_q <= 1'b0;
            refresh_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            beat_cnt_q  <= beat_cnt_d;
            passes_q    <= passes_d;
            pass_idx_q  <= pass_idx_d;
            mac_ready_q <= mac_ready_d;
            refresh_q   <= refresh_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        beat_cnt_d = beat_cnt_q;
        passes_d   = passes_q;
        pass_idx_d = pass_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (pixel_count != '0) && (pass_count != '0)) begin
                    pix_d      = pixel_count;
                    passes_d   = pass_count;
                    pass_idx_d = '0;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                beat_cnt_d = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (accept_c) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_d == pix_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_empty_c) begin
                    if (last_pass_c) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_idx_d = pass_idx_q + PASS_W'(1);
                        state_d    = ST_CLEAR;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        mac_ready_d = 1'b0;
        refresh_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mac_ready_d = (state_d == ST_RUN);
        refresh_d   = (state_d == ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // Beat pipeline matching the buffer read latency.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q   <= '0;
            pipe_first_q <= '0;
            pipe_last_q  <= '0;
            for (int unsigned i = 0; i < RL; i++) pipe_data_q[i] <= '0;
        end else begin
            pipe_vld_q[0]   <= accept_c;
            pipe_first_q[0] <= (pass_idx_q == '0);
            pipe_last_q[0]  <= last_pass_c;
            pipe_data_q[0]  <= mac_data;
            for (int unsigned i = 1; i < RL; i++) begin
                pipe_vld_q[i]   <= pipe_vld_q[i-1];
                pipe_first_q[i] <= pipe_first_q[i-1];
                pipe_last_q[i]  <= pipe_last_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
        end
    end

    accum_lane_adder #(
        .W (MAC_OUTPUT_WIDTH)
    ) u_adder (
        .clk         (system_clk),
        .rst         (rst),
        .valid_i     (pipe_vld_q[RL-1]),
        .first_i     (pipe_first_q[RL-1]),
        .last_i      (pipe_last_q[RL-1]),
        .mac_i       (pipe_data_q[RL-1]),
        .feat_i      (adder_feature),
        .wr_data_o   (feature_in),
        .wr_valid_o  (wr_valid),
        .out_data_o  (out_data),
        .out_valid_o (fin_valid)
    );

    assign mac_ready     = mac_ready_q;
    assign refresh_req   = refresh_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign feature_valid = wr_valid;
    assign out_valid     = fin_valid;
    // Read request must coincide with the accepted beat to meet the read alignment.
    assign adder_pulse   = accept_c & (pass_idx_q != '0);

endmodule

// File: doc/output_accum_ctrl.md
# output_accum_ctrl

Sequencer for the convolution output buffer that accumulates partial sums across input-channel passes. It sits between the MAC array and the output buffer.
- Drives the buffer's `refresh_req`, `adder_pulse`, `feature_in` and `feature_valid`.
- Adds each incoming MAC beat to the partial sum read back from the buffer.
- On the last pass, streams the final sums downstream instead of writing them back.

## Interface
- `MAC_OUTPUT_WIDTH`, default `` `MAC_OUTPUT_WIDTH ``: bit width of one lane; 8 lanes per beat.
- `ADDR_WIDTH`, default 15: buffer address width; bounds the pixel count.
- `READ_LATENCY`, default 3: cycles from `adder_pulse` to valid `adder_feature`.
- `system_clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle job start; honoured only in IDLE.
- `pixel_count`  in  ADDR_WIDTH+1  beats per pass (1..2^ADDR_WIDTH); sampled on `start`.
- `pass_count`  in  8  number of passes (1..255); sampled on `start`.
- `mac_valid`  in  1  MAC beat valid.
- `mac_ready`  out  1  beat accepted when `mac_valid && mac_ready`.
- `mac_data`  in  8*MAC_OUTPUT_WIDTH  MAC beat, 8 lanes.
- `refresh_req`  out  1  resets the buffer address pointers.
- `adder_pulse`  out  1  advances the buffer read pointer.
- `adder_feature`  in  8*MAC_OUTPUT_WIDTH  read data from the buffer.
- `feature_in`  out  8*MAC_OUTPUT_WIDTH  write data to the buffer.
- `feature_valid`  out  1  buffer write enable.
- `out_valid`  out  1  final-sum beat valid (last pass only).
- `out_data`  out  8*MAC_OUTPUT_WIDTH  final-sum beat.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  single-cycle pulse when the job completes.

## Operation
- **States:** IDLE, CLEAR, RUN, DRAIN, DONE.
- **IDLE.** On `start` with `pixel_count != 0` and `pass_count != 0`:
  - Latch both counts.
  - Set `pass_idx = 0` and go to CLEAR.
  - `start` with a zero count is ignored; the block stays in IDLE.
- **CLEAR.** Hold one cycle. `refresh_req = 1`. Clear `beat_cnt`. Go to RUN.
- **RUN.**
  - `mac_ready = 1`.
  - Each accepted beat increments `beat_cnt`.
  - If `pass_idx > 0`, the accepted beat also asserts `adder_pulse` combinationally in the same cycle.
  - When the accepted beat makes `beat_cnt == pixel_count`, go to DRAIN; `mac_ready` drops the next cycle.
- **Beat pipeline.**
  - Each accepted beat enters a shift pipeline of `READ_LATENCY` stages, carrying data, a valid bit, and first/last-pass flags.
  - At the pipeline output, `sum` per lane is:
    - pass 0: `sum = mac_lane`;
    - otherwise: `sum = mac_lane + adder_feature_lane`, two's-complement, modulo `2^MAC_OUTPUT_WIDTH` (wrap, no saturation).
  - If the beat belongs to the last pass (`pass_idx == pass_count-1`): register `sum` onto `out_data` and pulse `out_valid`; no buffer write.
  - Otherwise: register `sum` onto `feature_in` and pulse `feature_valid`.
  - The buffer's write pointer auto-increments, so writes land on the same address that was read.
- **DRAIN.** Wait until the pipeline and output register are empty. Then:
  - if `pass_idx == pass_count-1`, go to DONE;
  - else increment `pass_idx` and go to CLEAR.
- **DONE.** Pulse `done` for one cycle; return to IDLE.
- `start` outside IDLE is ignored.
- Reset mid-job: all state returns to IDLE immediately. The buffer contents are not cleared; the next job's CLEAR re-synchronises the pointers.

## Timing
- **Reset values:** state IDLE; all control outputs 0; `feature_in` and `out_data` 0.
- **Beat latency:** a beat accepted at cycle t produces `feature_valid` or `out_valid` at t+READ_LATENCY+1.
- **Read alignment:** `adder_pulse` at t pairs with `adder_feature` sampled at t+READ_LATENCY.
- **Pass overhead:** at least READ_LATENCY+2 DRAIN cycles plus 1 CLEAR cycle.
  - `refresh_req` never asserts while a write is pending.
- `mac_valid` may gap arbitrarily; throughput is 1 beat per cycle.
- `pixel_count = 2^ADDR_WIDTH`: the buffer pointers wrap to 0 exactly at the pass end, which is legal.
- `pass_count = 1`: no `adder_pulse` and no buffer writes; every beat goes to `out_valid`.

## Structure
- **Shared package / parameters header:** state encoding constants, and `READ_LATENCY` alongside `MAC_OUTPUT_WIDTH`.
- **Sub-module `accum_lane_adder`:** 8-lane wrap-around adder with a pass-0 bypass and a registered output. Instantiated once.

## Test plan
- **Single pass:** `pass_count=1`, `pixel_count=4`, lanes = beat index.
  - `out_valid` ×4 with identical data; `feature_valid` and `adder_pulse` never assert; `done` 1 cycle after the last `out_valid` drains.
- **Three passes:** `pixel_count=3`, each lane = 1 per beat.
  - Passes 0 and 1 write 1 then 2.
  - `out_data` lanes = 3 on every final beat.
  - `refresh_req` asserts exactly 3 times.
- **Wrap arithmetic:** `MAC_OUTPUT_WIDTH=8`, pass 0 lane = 0xF0, pass 1 lane = 0x20 → `out_data` lane = 0x10.
- **Bubbled input:** `mac_valid` toggling 1-0-0-1, `pixel_count=5`, 2 passes.
  - Sums correct.
  - `adder_pulse` count equals accepted beats in pass 1 (5).
- **Abort and ignored starts:**
  - Assert `rst` during RUN of pass 1 → all outputs 0 next edge, state IDLE.
  - A fresh job then completes correctly.
  - `start` with `pixel_count=0` produces no `busy`.
- **Max size:** `pixel_count=2^ADDR_WIDTH`, 2 passes → exactly 2^ADDR_WIDTH writes, then 2^ADDR_WIDTH `out_valid`; `done` asserts once.
